// File: rtl/sfu_issue.sv
// -----------------------------------------------------------------------------
// sfu_issue
//
// Core-side initiator for the special function unit. Takes one multi-lane SFU
// instruction from the execute stage, feeds its active lanes into the
// single-lane SFU port one per cycle, collects the in-order scalar results back
// into a lane vector and hands them to the core as a single response. The
// pipeline flush is forwarded to the SFU unchanged.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
// both are high. The request side is held by the core until req_ready_o; the
// response is held stable by this block until rsp_ready_i. The SFU side has no
// back-pressure: sfu_valid_o marks a one-cycle operand beat, and sfu_valid_i
// marks a one-cycle result beat, with results returning in issue order.
//
// Ports:
//   core_clock_i, core_reset_ni   clock, synchronous active-low reset
//   flush_i                       abandon the current instruction
//   req_valid_i / req_ready_o     instruction handshake
//   req_op_i, req_operands_i,
//   req_mask_i                    op select, lane operands, active-lane mask
//   sfu_operand_o, sfu_special_op_o,
//   sfu_valid_o                   registered operand beat to the SFU
//   sfu_flush_o                   flush_i, passed straight through
//   sfu_result_i, sfu_valid_i     result beat from the SFU
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_results_o, rsp_mask_o     collected results (inactive lanes 0), mask
//   dbg_state                     current FSM state (IDLE=0 ISSUE=1 DRAIN=2 RESP=3)
// -----------------------------------------------------------------------------
module sfu_issue #(
    parameter int LANES = 4
) (
    input  logic                  core_clock_i,
    input  logic                  core_reset_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [LANES*24-1:0]   req_operands_i,
    input  logic [LANES-1:0]      req_mask_i,
    output logic [23:0]           sfu_operand_o,
    output logic [2:0]            sfu_special_op_o,
    output logic                  sfu_valid_o,
    output logic                  sfu_flush_o,
    input  logic [23:0]           sfu_result_i,
    input  logic                  sfu_valid_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [LANES*24-1:0]   rsp_results_o,
    output logic [LANES-1:0]      rsp_mask_o,
    output logic [1:0]            dbg_state
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(LANES + 1);
    localparam logic [LANES-1:0] LANE_ONE = 1;
    localparam logic [CW-1:0]    CNT_ONE  = 1;
    localparam logic [IW-1:0]    IDX_ONE  = 1;
    localparam logic [IW-1:0]    IDX_LAST = IW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;         // lane currently on the SFU outputs
    logic [LANES-1:0]      pend;        // lanes issued but not yet returned
    logic [CW-1:0]         cnt;         // outstanding results
    logic [LANES*24-1:0]   operands_q;
    logic [2:0]            op_q;

    logic                  issue_go;
    logic                  issue_fire;
    logic                  collect;
    logic [IW-1:0]         issue_lane;
    logic [IW-1:0]         ret_lane;
    logic [LANES-1:0]      src_mask;
    logic [LANES*24-1:0]   src_operands;
    logic [2:0]            src_op;
    logic [LANES-1:0]      set_bits;
    logic [LANES-1:0]      clr_bits;
    logic [LANES-1:0]      pend_next;
    logic [CW-1:0]         cnt_next;

    assign sfu_flush_o = flush_i;
    assign req_ready_o = core_reset_ni && (state == IDLE);
    assign dbg_state   = state;

    always_comb begin
        // The SFU outputs are registered, so the lane shown next cycle is
        // chosen now: lane 0 on the accepting edge (straight from the request
        // bus), then idx+1 on each ISSUE edge until the last lane is shown.
        src_mask     = (state == IDLE) ? req_mask_i     : rsp_mask_o;
        src_operands = (state == IDLE) ? req_operands_i : operands_q;
        src_op       = (state == IDLE) ? req_op_i       : op_q;

        issue_go   = 1'b0;
        issue_lane = '0;
        if (state == IDLE) begin
            issue_go = req_valid_i;
        end else if (state == ISSUE && idx != IDX_LAST) begin
            issue_go   = 1'b1;
            issue_lane = idx + IDX_ONE;
        end
        issue_fire = issue_go && src_mask[issue_lane];

        // Results return in issue order, so the oldest outstanding lane is
        // always the lowest set pend bit.
        collect  = sfu_valid_i && (pend != '0) && (state == ISSUE || state == DRAIN);
        ret_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend[i]) ret_lane = IW'(i);
        end

        set_bits  = issue_fire ? (LANE_ONE << issue_lane) : '0;
        clr_bits  = collect    ? (LANE_ONE << ret_lane)   : '0;
        pend_next = (pend & ~clr_bits) | set_bits;

        cnt_next = cnt;
        if (issue_fire && !collect)      cnt_next = cnt + CNT_ONE;
        else if (!issue_fire && collect) cnt_next = cnt - CNT_ONE;
    end

    always_ff @(posedge core_clock_i) begin
        if (!core_reset_ni) begin
            state            <= IDLE;
            idx              <= '0;
            pend             <= '0;
            cnt              <= '0;
            operands_q       <= '0;
            op_q             <= '0;
            sfu_valid_o      <= 1'b0;
            sfu_operand_o    <= '0;
            sfu_special_op_o <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_results_o    <= '0;
            rsp_mask_o       <= '0;
        end else if (flush_i) begin
            // Results still in flight land while IDLE and are dropped there.
            state       <= IDLE;
            idx         <= '0;
            pend        <= '0;
            cnt         <= '0;
            sfu_valid_o <= 1'b0;
            rsp_valid_o <= 1'b0;
        end else begin
            pend        <= pend_next;
            cnt         <= cnt_next;
            sfu_valid_o <= issue_fire;
            if (issue_fire) begin
                sfu_operand_o    <= src_operands[24*int'(issue_lane) +: 24];
                sfu_special_op_o <= src_op;
            end
            if (collect) begin
                rsp_results_o[24*int'(ret_lane) +: 24] <= sfu_result_i;
            end

            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        operands_q    <= req_operands_i;
                        op_q          <= req_op_i;
                        rsp_mask_o    <= req_mask_i;
                        rsp_results_o <= '0;
                        idx           <= '0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (idx == IDX_LAST) state <= DRAIN;
                    else                 idx   <= idx + IDX_ONE;
                end
                DRAIN: begin
                    if (pend_next == '0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_issue.sv
module tb_sfu_issue;

    localparam int LANES = 4;
    localparam int SW    = 32 + 3 + 24;
    localparam int RW    = 32 + LANES + LANES * 24;

    logic                  clk;
    logic                  core_reset_ni;
    logic                  flush_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [2:0]            req_op_i;
    logic [LANES*24-1:0]   req_operands_i;
    logic [LANES-1:0]      req_mask_i;
    logic [23:0]           sfu_operand_o;
    logic [2:0]            sfu_special_op_o;
    logic                  sfu_valid_o;
    logic                  sfu_flush_o;
    logic [23:0]           sfu_result_i;
    logic                  sfu_valid_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [LANES*24-1:0]   rsp_results_o;
    logic [LANES-1:0]      rsp_mask_o;
    logic [1:0]            dbg_state;

    sfu_issue #(.LANES(LANES)) dut (
        .core_clock_i     (clk),
        .core_reset_ni    (core_reset_ni),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_operands_i   (req_operands_i),
        .req_mask_i       (req_mask_i),
        .sfu_operand_o    (sfu_operand_o),
        .sfu_special_op_o (sfu_special_op_o),
        .sfu_valid_o      (sfu_valid_o),
        .sfu_flush_o      (sfu_flush_o),
        .sfu_result_i     (sfu_result_i),
        .sfu_valid_i      (sfu_valid_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_results_o    (rsp_results_o),
        .rsp_mask_o       (rsp_mask_o),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [SW-1:0] exp_sfu_q[$];   // {cycle, op, operand}
    logic [RW-1:0] exp_rsp_q[$];   // {first valid cycle, mask, results}
    logic [55:0]   ret_q[$];       // SFU model: {return cycle, result}
    logic [RW-1:0] cur_rsp;
    logic          rsp_active = 1'b0;
    logic          chk_ready  = 1'b0;
    int            lat        = 1;
    int            rsp_mode   = 0;  // 0: ready high, 1: ready low, 2: random

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // ---------------- SFU model: result = operand + 1 after lat cycles ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (core_reset_ni && sfu_valid_o === 1'b1)
                ret_q.push_back({32'(cyc + lat), sfu_operand_o + 24'd1});
        end
    end

    initial begin
        logic [55:0] r;
        sfu_valid_i  = 1'b0;
        sfu_result_i = '0;
        forever begin
            @(posedge clk);
            #1;
            while (ret_q.size() > 0 && int'(ret_q[0][55:24]) < cyc) r = ret_q.pop_front();
            if (ret_q.size() > 0 && int'(ret_q[0][55:24]) == cyc) begin
                r            = ret_q.pop_front();
                sfu_valid_i  = 1'b1;
                sfu_result_i = r[23:0];
            end else begin
                sfu_valid_i  = 1'b0;
                sfu_result_i = 24'($urandom);
            end
        end
    end

    // ---------------- response ready driver ----------------
    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready_i = 1'b1;
                1:       rsp_ready_i = 1'b0;
                default: rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [SW-1:0] e;
        forever begin
            @(negedge clk);
            if (core_reset_ni) begin
                if (sfu_valid_o === 1'b1) begin
                    if (exp_sfu_q.size() == 0) fail_now("sfu_unexpected_issue");
                    else begin
                        e = exp_sfu_q.pop_front();
                        check("sfu_issue", 160'({32'(cyc), sfu_special_op_o, sfu_operand_o}), 160'(e));
                    end
                end
                if (chk_ready) begin
                    check("ready_after_rsp", 160'(req_ready_o), 160'(1));
                    chk_ready = 1'b0;
                end
                if (rsp_valid_o === 1'b1) begin
                    if (!rsp_active) begin
                        if (exp_rsp_q.size() == 0) begin
                            fail_now("rsp_unexpected");
                            cur_rsp = {32'(cyc), rsp_mask_o, rsp_results_o};
                        end else begin
                            cur_rsp = exp_rsp_q.pop_front();
                            check("rsp_cycle", 160'(cyc), 160'(cur_rsp[RW-1 -: 32]));
                        end
                        rsp_active = 1'b1;
                    end
                    check("rsp_data", 160'({rsp_mask_o, rsp_results_o}), 160'(cur_rsp[RW-33:0]));
                    check("rsp_busy_ready", 160'(req_ready_o), 160'(0));
                    if (rsp_ready_i) begin
                        rsp_active = 1'b0;
                        chk_ready  = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Reference: lane i issues at T+1+i; its result returns lat cycles later;
    // the response appears one cycle after the later of the last return and
    // the single DRAIN cycle that follows the LANES-cycle issue window.
    task automatic send(input logic [LANES*24-1:0] ops, input logic [LANES-1:0] mask,
                        input logic [2:0] op, input int l, input int flush_off);
        int t;
        int n = 0;
        int last_ret = -1;
        int rc;
        logic [LANES*24-1:0] res;
        @(posedge clk);
        #1;
        while (req_ready_o !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            fail_now("req_ready_timeout");
            return;
        end
        lat            = l;
        req_valid_i    = 1'b1;
        req_operands_i = ops;
        req_mask_i     = mask;
        req_op_i       = op;
        t              = cyc;
        res            = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i] && (flush_off < 0 || 1 + i <= flush_off)) begin
                exp_sfu_q.push_back({32'(t + 1 + i), op, ops[24*i +: 24]});
                res[24*i +: 24] = ops[24*i +: 24] + 24'd1;
                last_ret        = t + 1 + i + l;
            end
        end
        if (flush_off < 0) begin
            rc = ((last_ret > t + LANES + 1) ? last_ret : t + LANES + 1) + 1;
            exp_rsp_q.push_back({32'(rc), mask, res});
        end
        @(posedge clk);
        #1;
        req_valid_i    = 1'b0;
        req_operands_i = {$urandom, $urandom, $urandom};
        req_mask_i     = 4'($urandom);
        req_op_i       = 3'($urandom);
        if (flush_off >= 0) begin
            repeat (flush_off - 1) begin
                @(posedge clk);
                #1;
            end
            flush_i = 1'b1;
            @(negedge clk);
            check("sfu_flush_follows", 160'(sfu_flush_o), 160'(1));
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            @(negedge clk);
            check("sfu_flush_low", 160'(sfu_flush_o), 160'(0));
            check("flush_sfu_valid", 160'(sfu_valid_o), 160'(0));
            check("flush_state", 160'(dbg_state), 160'(0));
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_rsp_q.size() != 0 || rsp_active || exp_sfu_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) fail_now("done_timeout");
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk);
    endtask

    // ---------------- test sequence ----------------
    localparam logic [LANES*24-1:0] BASE_OPS = {24'h000400, 24'h000300, 24'h000200, 24'h000100};

    initial begin
        int n;
        logic [LANES*24-1:0] ops;
        core_reset_ni  = 1'b0;
        flush_i        = 1'b0;
        req_valid_i    = 1'b0;
        req_op_i       = '0;
        req_operands_i = '0;
        req_mask_i     = '0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 160'(req_ready_o), 160'(0));
        check("reset_sfu_valid", 160'(sfu_valid_o), 160'(0));
        check("reset_sfu_operand", 160'(sfu_operand_o), 160'(0));
        check("reset_sfu_op", 160'(sfu_special_op_o), 160'(0));
        check("reset_rsp_valid", 160'(rsp_valid_o), 160'(0));
        check("reset_rsp_results", 160'(rsp_results_o), 160'(0));
        check("reset_rsp_mask", 160'(rsp_mask_o), 160'(0));
        check("reset_flush_pass", 160'(sfu_flush_o), 160'(1));
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        core_reset_ni = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 160'(req_ready_o), 160'(1));

        // full mask, latency 3
        send(BASE_OPS, 4'b1111, 3'd1, 3, -1);
        wait_done();
        // mask 0101, latency 1
        send(BASE_OPS, 4'b0101, 3'd1, 1, -1);
        wait_done();
        // empty mask
        send(BASE_OPS, 4'b0000, 3'd2, 1, -1);
        wait_done();

        // response held for several cycles
        @(negedge clk);
        rsp_mode = 1;
        send(BASE_OPS, 4'b1011, 3'd5, 2, -1);
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("stall_rsp_timeout");
        repeat (5) @(negedge clk);
        rsp_mode = 0;
        wait_done();

        // flush during ISSUE; late results must be ignored
        send(BASE_OPS, 4'b1111, 3'd1, 3, 2);
        repeat (10) begin
            @(negedge clk);
            check("flush_no_rsp", 160'(rsp_valid_o), 160'(0));
        end
        send({24'h0000aa, 24'h0000bb, 24'h0000cc, 24'h0000dd}, 4'b1110, 3'd3, 2, -1);
        wait_done();

        // reset while draining
        send(BASE_OPS, 4'b1111, 3'd4, 5, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_state", 160'(dbg_state), 160'(2));
        @(posedge clk);
        #1;
        core_reset_ni = 1'b0;
        exp_rsp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_sfu_valid", 160'(sfu_valid_o), 160'(0));
        check("rst_sfu_operand", 160'(sfu_operand_o), 160'(0));
        check("rst_sfu_op", 160'(sfu_special_op_o), 160'(0));
        check("rst_rsp_valid", 160'(rsp_valid_o), 160'(0));
        check("rst_rsp_results", 160'(rsp_results_o), 160'(0));
        check("rst_rsp_mask", 160'(rsp_mask_o), 160'(0));
        check("rst_req_ready", 160'(req_ready_o), 160'(0));
        @(posedge clk);
        #1;
        core_reset_ni = 1'b1;
        ret_q.push_back({32'(cyc + 1), 24'h5a5a5a});
        @(negedge clk);
        check("rst_release_ready", 160'(req_ready_o), 160'(1));
        repeat (6) @(negedge clk);
        check("stray_rsp_valid", 160'(rsp_valid_o), 160'(0));
        check("stray_results", 160'(rsp_results_o), 160'(0));
        check("stray_state", 160'(dbg_state), 160'(0));
        send(BASE_OPS, 4'b0110, 3'd6, 1, -1);
        wait_done();

        // randomized traffic with random response back-pressure
        @(negedge clk);
        rsp_mode = 2;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < LANES; i++) ops[24*i +: 24] = 24'($urandom);
            send(ops, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom_range(1, 6), -1);
            wait_done();
        end
        @(negedge clk);
        rsp_mode = 0;
        idle_cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sfu_issue.md
# sfu_issue

Core-side initiator for the special function unit's single-lane request/result port. It accepts one multi-lane SFU instruction (operand vector, lane mask, op select) from the core and serializes active lanes into the SFU one per cycle. It collects the in-order scalar results back into a lane vector and presents them as one response. It sits between the core's execute stage and the `sfu` block, and also forwards the pipeline flush to it.

## Interface

Parameters:
- `LANES`, default 4: lanes per instruction; power of two, 2..16.

Ports:
- `core_clock_i`, in, 1: single clock.
- `core_reset_ni`, in, 1: reset, synchronous, active-low.
- `flush_i`, in, 1: pipeline flush; abandons the current instruction.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: issuer idle and able to accept.
- `req_op_i`, in, 3: special op select, passed unchanged to the SFU.
- `req_operands_i`, in, `LANES*24`: lane i at bits [24i+23:24i].
- `req_mask_i`, in, `LANES`: active-lane mask.
- `sfu_operand_o`, out, 24: operand to the SFU.
- `sfu_special_op_o`, out, 3: op to the SFU.
- `sfu_valid_o`, out, 1: operand valid to the SFU.
- `sfu_flush_o`, out, 1: equals `flush_i` (combinational).
- `sfu_result_i`, in, 24: SFU result.
- `sfu_valid_i`, in, 1: SFU result valid; results return in issue order with arbitrary latency.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response accepted.
- `rsp_results_o`, out, `LANES*24`: collected results; inactive lanes are 0.
- `rsp_mask_o`, out, `LANES`: copy of the request mask.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE
  - `req_ready_o`=1.
  - On `req_valid_i`: latch operands, mask and op; clear the result buffer; set lane index to 0; go to ISSUE.
- ISSUE
  - Each cycle handles lane index i (0..LANES-1). If `mask[i]`: drive operand i and op with `sfu_valid_o`=1, set `pend[i]`, and increment the outstanding counter.
  - An inactive lane consumes the cycle with `sfu_valid_o`=0.
  - After lane LANES-1, go to DRAIN.
- Collection runs in ISSUE and DRAIN.
  - On `sfu_valid_i`, write `sfu_result_i` to the lowest set bit of `pend`, clear that bit, and decrement the counter.
  - Issue and return in the same cycle leave the counter unchanged.
  - `sfu_valid_i` with `pend`=0 is ignored.
- DRAIN: when `pend`=0 (including a returning result that clears the last bit), go to RESP.
- RESP: `rsp_valid_o`=1 with `rsp_results_o` and `rsp_mask_o` stable. On `rsp_ready_i`, go to IDLE.
- Outstanding counter width is clog2(LANES+1) and never exceeds LANES.
- Flush (any state):
  - Next state is IDLE; `pend`, counter and lane index are cleared; `sfu_valid_o`=0 next cycle.
  - Any response is dropped. Results arriving in or after the flush cycle are ignored.
  - `req_valid_i` in the flush cycle is not accepted.
- Reset (any state, priority over flush): IDLE, all registers cleared.

## Timing

- Reset values:
  - `req_ready_o`=0 while `core_reset_ni`=0, then 1.
  - `sfu_valid_o`, `sfu_operand_o`, `sfu_special_op_o`, `rsp_valid_o`, `rsp_results_o`, `rsp_mask_o` = 0.
- Handshake at cycle T: lane i appears on the SFU outputs at T+1+i (registered outputs). The ISSUE phase is always exactly LANES cycles.
- A result accepted at cycle R that clears the last `pend` bit (with ISSUE complete) gives `rsp_valid_o`=1 at R+1.
- Response accepted at cycle A: `req_ready_o`=1 at A+1. There is no overlap between instructions.
- Mask = 0: no SFU traffic; `rsp_valid_o` at T+LANES+2 with all zeros.
- `sfu_flush_o` follows `flush_i` in the same cycle.

## Test plan

- Full mask, LANES=4. Operands 0x000100/0x000200/0x000300/0x000400, op 3'd1, SFU model returns operand+1 at latency 3.
  - Required: `sfu_valid_o` at T+1..T+4 with those operands and op 1.
  - Required: `rsp_valid_o` at T+8 with 0x000101/0x000201/0x000301/0x000401, mask 4'b1111.
- Mask 4'b0101, model latency 1. Required: SFU sees only 0x000100 (T+1) and 0x000300 (T+3); response lanes 1 and 3 are 0; mask 4'b0101.
- Mask 0: no `sfu_valid_o`; `rsp_valid_o` at T+6 with all-zero results.
- Hold `rsp_ready_i`=0 for 5 cycles.
  - Required: response stable and `req_ready_o`=0 throughout.
  - Required: `req_ready_o`=1 the cycle after `rsp_ready_i`=1.
- Flush at T+2 (latency 3).
  - Required: `sfu_flush_o`=1 that cycle, `sfu_valid_o`=0 from T+3, no response.
  - Required: late `sfu_valid_i` ignored; the next request completes correctly.
- `core_reset_ni`=0 during DRAIN. Required: all outputs 0 next cycle; `req_ready_o`=1 after reset releases; a stray `sfu_valid_i` does not alter state.
